pattern_tx_1101: RTL and testbench

//   Serial pattern transmitter; the generating end of the serial "1101" detection link.
//   On a start request it latches an N-bit pattern (default 4'b1101) and a repeat count.
//   It then shifts the pattern out MSB-first, one bit per clock, repeated back-to-back.
//   An optional idle gap can separate repetitions.

---
 rtl/pattern_tx_1101_if.sv | 24 ++
 rtl/pattern_tx_1101.sv | 83 ++++++++
 tb/tb_pattern_tx_1101.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pattern_tx_1101_if.sv
// pattern_tx_1101_if: request/serial-output bundle for the pattern transmitter.
//   start/pattern_in/rep_cnt: transfer request; serial_out/bit_valid: serial stream;
//   busy/done/state: transmitter status.
interface pattern_tx_1101_if #(
  parameter int PAT_WIDTH = 4,
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic [PAT_WIDTH-1:0] pattern_in;
  logic [CNT_WIDTH-1:0] rep_cnt;
  logic                 serial_out;
  logic                 bit_valid;
  logic                 busy;
  logic                 done;
  logic [1:0]           state;
  modport master (
    output start, pattern_in, rep_cnt,
    input  serial_out, bit_valid, busy, done, state
  );
  modport slave (
    input  start, pattern_in, rep_cnt,
    output serial_out, bit_valid, busy, done, state
  );
endinterface

// File: rtl/pattern_tx_1101.sv
// pattern_tx_1101: repeats a latched pattern MSB-first on a serial line with optional idle gaps.
//   clk, n_rst (async active-low); tx.start/pattern_in/rep_cnt request a transfer;
//   tx.serial_out/bit_valid carry the stream; tx.busy/done/state report progress.
module pattern_tx_1101 #(
  parameter int PAT_WIDTH = 4,
  parameter int CNT_WIDTH = 4,
  parameter int GAP_LEN   = 0
) (
  input  logic               clk,
  input  logic               n_rst,
  pattern_tx_1101_if.slave   tx
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  localparam int BW = $clog2(PAT_WIDTH);
  localparam int GW = $clog2(GAP_LEN + 2);
  localparam logic [BW-1:0] BIT_TOP = BW'(PAT_WIDTH - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP_LEN - 1);
  state_t               state_q, state_d;
  logic [PAT_WIDTH-1:0] sr_q, sr_d, pat_q, pat_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CNT_WIDTH-1:0] rep_q, rep_d;
  logic [GW-1:0]        gap_q, gap_d;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (tx.start && tx.rep_cnt != '0) begin
        state_d = SHIFT;
        pat_d   = tx.pattern_in;
        sr_d    = tx.pattern_in;
        rep_d   = tx.rep_cnt;
        bit_d   = BIT_TOP;
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        bit_d = bit_q - BW'(1);
        if (bit_q == '0) begin
          rep_d = rep_q - CNT_WIDTH'(1);
          if (rep_q == CNT_WIDTH'(1)) state_d = DONE;
          else if (GAP_LEN > 0) begin
            state_d = GAP;
            gap_d   = GAP_TOP;
          end else begin
            sr_d  = pat_q;
            bit_d = BIT_TOP;
          end
        end
      end
      GAP: if (gap_q == '0) begin
        state_d = SHIFT;
        sr_d    = pat_q;
        bit_d   = BIT_TOP;
      end else gap_d = gap_q - GW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end
  assign tx.serial_out = (state_q == SHIFT) && sr_q[PAT_WIDTH-1];
  assign tx.bit_valid  = state_q == SHIFT;
  assign tx.busy       = state_q != IDLE;
  assign tx.done       = state_q == DONE;
  assign tx.state      = state_q;
endmodule

// File: tb/tb_pattern_tx_1101.sv
// tb_pattern_tx_1101: directed table-driven checks of the pattern transmitter.
module tb_pattern_tx_1101;
  logic clk = 0;
  logic n_rst = 0;
  always #5 clk = ~clk;
  pattern_tx_1101_if ia ();
  pattern_tx_1101_if ib ();
  pattern_tx_1101 #(.GAP_LEN(0)) dut_a (.clk(clk), .n_rst(n_rst), .tx(ia.slave));
  pattern_tx_1101 #(.GAP_LEN(2)) dut_b (.clk(clk), .n_rst(n_rst), .tx(ib.slave));
  int n_cmp = 0;
  int n_bad = 0;
  logic sel = 0;
  logic so, bv, bz, dn;
  logic [1:0] st;
  assign so = sel ? ib.serial_out : ia.serial_out;
  assign bv = sel ? ib.bit_valid  : ia.bit_valid;
  assign bz = sel ? ib.busy       : ia.busy;
  assign dn = sel ? ib.done       : ia.done;
  assign st = sel ? ib.state      : ia.state;
  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    logic        gap;
    logic [15:0] bits;
    logic [15:0] valid;
    int          n;
    int          hits;
  } vec_t;
  vec_t vt [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [3:0] pat, input logic [3:0] rep, input logic sa, input logic sb);
    ia.pattern_in = pat;
    ib.pattern_in = pat;
    ia.rep_cnt    = rep;
    ib.rep_cnt    = rep;
    ia.start      = sa;
    ib.start      = sb;
  endtask
  task automatic run(input vec_t v);
    int hits = 0;
    logic [3:0] h = '0;
    sel = v.gap;
    @(negedge clk);
    drive(v.pat, v.rep, !v.gap, v.gap);
    @(negedge clk);
    drive(v.pat, v.rep, 0, 0);
    for (int i = 1; i <= v.n; i++) begin
      if (i < v.n) begin
        chk("serial_out", 32'(so), 32'(v.bits[v.n-1-i]));
        chk("bit_valid", 32'(bv), 32'(v.valid[v.n-1-i]));
      end
      chk("done", 32'(dn), 32'(i == v.n));
      chk("busy", 32'(bz), 1);
      if (bv) begin
        h = {h[2:0], so};
        if (h == 4'b1101) hits++;
      end
      @(negedge clk);
    end
    chk("idle_after", 32'(st), 0);
    chk("hits", 32'(hits), 32'(v.hits));
  endtask
  initial begin
    int cnt;
    logic [3:0] got;
    vt[0] = '{4'b1101, 4'd1, 1'b0, 16'b1101,         16'b1111,         5,  1};
    vt[1] = '{4'b1101, 4'd3, 1'b0, 16'b110111011101, 16'b111111111111, 13, 3};
    vt[2] = '{4'b1101, 4'd2, 1'b1, 16'b1101001101,   16'b1111001111,   11, 2};
    vt[3] = '{4'b1010, 4'd1, 1'b0, 16'b1010,         16'b1111,         5,  0};
    vt[4] = '{4'b0110, 4'd2, 1'b1, 16'b0110000110,   16'b1111001111,   11, 0};
    vt[5] = '{4'b0011, 4'd2, 1'b0, 16'b00110011,     16'b11111111,     9,  0};
    drive(4'b0, 4'd0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(ia.state), 0);
    chk("rst_serial", 32'(ia.serial_out), 0);
    chk("rst_valid", 32'(ia.bit_valid), 0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_done", 32'(ia.done), 0);
    n_rst = 1;
    for (int k = 0; k < 6; k++) run(vt[k]);
    sel = 0;
    drive(4'b1101, 4'd0, 1, 0);
    @(negedge clk);
    drive(4'b1101, 4'd0, 0, 0);
    chk("zero_cnt_state", 32'(ia.state), 0);
    chk("zero_cnt_busy", 32'(ia.busy), 0);
    @(negedge clk);
    chk("zero_cnt_state2", 32'(ia.state), 0);
    drive(4'b1101, 4'd1, 1, 0);
    @(negedge clk);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(4'b1101, 4'd2, i <= 4, 0);
      if (ia.done) cnt++;
      @(negedge clk);
    end
    chk("busy_start_dones", 32'(cnt), 1);
    chk("busy_start_idle", 32'(ia.state), 0);
    drive(4'b1101, 4'd1, 1, 0);
    @(negedge clk);
    drive(4'b0010, 4'd5, 0, 0);
    got = '0;
    for (int i = 1; i <= 4; i++) begin
      got = {got[2:0], ia.serial_out};
      @(negedge clk);
    end
    chk("late_change_bits", 32'(got), 32'(4'b1101));
    chk("late_change_done", 32'(ia.done), 1);
    @(negedge clk);
    chk("late_change_idle", 32'(ia.state), 0);
    drive(4'b1101, 4'd3, 1, 0);
    @(negedge clk);
    drive(4'b1101, 4'd3, 0, 0);
    repeat (4) @(negedge clk);
    chk("mid_shift_state", 32'(ia.state), 1);
    n_rst = 0;
    #1;
    chk("abort_state", 32'(ia.state), 0);
    chk("abort_serial", 32'(ia.serial_out), 0);
    chk("abort_busy", 32'(ia.busy), 0);
    chk("abort_done", 32'(ia.done), 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ia.done) cnt++;
    end
    n_rst = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ia.done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 0);
    chk("abort_idle", 32'(ia.state), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
